// File: rtl/karatsuba_pkg.sv
// Shared sizing for the nibble-serial Karatsuba multiplier.
package karatsuba_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned OP_W    = 64;
    localparam int unsigned HALF_W  = OP_W / 2;
    localparam int unsigned NDIG    = OP_W / DIGIT_W;
    localparam int unsigned CNT_W   = $clog2(NDIG);

endpackage

// File: rtl/karatsuba_core64.sv
// Two-stage Karatsuba multiplier: stage 1 registers z2, z0 and zm; stage 2 registers the product.
// The pipeline runs every cycle. Its operands only change when a frame completes, so the
// output only moves when a new result arrives.
module karatsuba_core64
    import karatsuba_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [2*OP_W-1:0] p
);

    logic [HALF_W-1:0] a_hi, a_lo, b_hi, b_lo;
    logic [HALF_W:0]   sa, sb;
    logic [OP_W-1:0]   z2_q, z0_q;
    logic [OP_W+1:0]   zm_q;
    logic [OP_W+1:0]   z1;
    logic [2*OP_W-1:0] p_d;

    // Split the operands into halves and form the 33-bit half sums.
    always_comb begin
        a_hi = a[OP_W-1:HALF_W];
        a_lo = a[HALF_W-1:0];
        b_hi = b[OP_W-1:HALF_W];
        b_lo = b[HALF_W-1:0];
        sa   = {1'b0, a_hi} + {1'b0, a_lo};
        sb   = {1'b0, b_hi} + {1'b0, b_lo};
    end

    // Recombine. z1 is always non-negative and fits in 65 bits.
    // z2 and z0 do not overlap, so they concatenate directly.
    always_comb begin
        z1  = zm_q - {2'b00, z2_q} - {2'b00, z0_q};
        p_d = {z2_q, z0_q} + ({{(OP_W - 2){1'b0}}, z1} << HALF_W);
    end

    // Stage 1 holds the sub-products. Stage 2 holds the final product.
    always_ff @(posedge clk) begin
        if (!rst) begin
            z2_q <= '0;
            z0_q <= '0;
            zm_q <= '0;
            p    <= '0;
        end else begin
            z2_q <= OP_W'(a_hi) * OP_W'(b_hi);
            z0_q <= OP_W'(a_lo) * OP_W'(b_lo);
            zm_q <= (OP_W + 2)'(sa) * (OP_W + 2)'(sb);
            p    <= p_d;
        end
    end

endmodule

// File: rtl/karatsuba_serial_mult.sv
// Nibble-serial 64x64 multiplier front end.
// It deserialises two MS-digit-first operand streams and feeds the Karatsuba core.
module karatsuba_serial_mult
    import karatsuba_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIGIT_W-1:0] Data_in1,
    input  logic [DIGIT_W-1:0] Data_in2,
    output logic [2*OP_W-1:0]  Data_out
);

    // A count of zero means idle. Counts 1..NDIG-1 mean a frame is in progress.
    logic [CNT_W-1:0] cnt_q;
    logic [OP_W-1:0]  sh_a_q, sh_b_q;
    logic [OP_W-1:0]  sh_a_d, sh_b_d;
    logic [OP_W-1:0]  op_a_q, op_b_q;

    // Shift each new digit into the LS end of the accumulated operand.
    always_comb begin
        sh_a_d = {sh_a_q[OP_W-DIGIT_W-1:0], Data_in1};
        sh_b_d = {sh_b_q[OP_W-DIGIT_W-1:0], Data_in2};
    end

    // Deserialiser and operand load. A start pulse always restarts the frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            sh_a_q <= '0;
            sh_b_q <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (start) begin
            sh_a_q <= {{(OP_W - DIGIT_W){1'b0}}, Data_in1};
            sh_b_q <= {{(OP_W - DIGIT_W){1'b0}}, Data_in2};
            cnt_q  <= CNT_W'(1);
        end else if (cnt_q != '0) begin
            sh_a_q <= sh_a_d;
            sh_b_q <= sh_b_d;
            if (cnt_q == CNT_W'(NDIG - 1)) begin
                op_a_q <= sh_a_d;
                op_b_q <= sh_b_d;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    karatsuba_core64 u_core (
        .clk (clk),
        .rst (rst),
        .a   (op_a_q),
        .b   (op_b_q),
        .p   (Data_out)
    );

endmodule

// File: tb/tb_karatsuba_serial_mult.sv
// Bench for karatsuba_serial_mult.
// A frame-level reference model predicts Data_out on every cycle.
// Each directed case also checks the sequence of distinct output values against hand-worked literals.
module tb_karatsuba_serial_mult;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   Data_in1, Data_in2;
    logic [127:0] Data_out;

    int n_cmp = 0;
    int n_err = 0;

    karatsuba_serial_mult dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Data_in1 (Data_in1),
        .Data_in2 (Data_in2),
        .Data_out (Data_out)
    );

    always #5 clk = ~clk;

    // Reference model: collect 16 digits per frame.
    // The product A*B becomes visible two edges after the frame's last digit.
    typedef struct {
        int           due;
        logic [127:0] v;
    } pend_t;

    pend_t        pend[$];
    logic [127:0] exp_out = '0;
    logic [63:0]  acc_a, acc_b;
    int           ndig = 0;
    int           cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            pend.delete();
            exp_out = '0;
            ndig    = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_out = pend[0].v;
                void'(pend.pop_front());
            end
            if (start) begin
                acc_a = 64'(Data_in1);
                acc_b = 64'(Data_in2);
                ndig  = 1;
            end else if (ndig > 0) begin
                acc_a = acc_a * 64'd16 + 64'(Data_in1);
                acc_b = acc_b * 64'd16 + 64'(Data_in2);
                ndig++;
                if (ndig == 16) begin
                    pend.push_back('{due: cyc + 2, v: 128'(acc_a) * 128'(acc_b)});
                    ndig = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of every distinct output value.
    logic [127:0] seen[$];
    logic [127:0] last_out = '0;

    always @(negedge clk) begin
        n_cmp++;
        if (Data_out !== exp_out) begin
            n_err++;
            $display("FAIL cycle %0d data_out: got %h expected %h", cyc, Data_out, exp_out);
        end
        if (Data_out !== last_out) begin
            seen.push_back(Data_out);
            last_out = Data_out;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start    = 1'b0;
            Data_in1 = 4'($urandom);
            Data_in2 = 4'($urandom);
        end
    endtask

    // Drive the first nd digits of a frame, MS digit first.
    task automatic send_frame(input logic [63:0] a, input logic [63:0] b, input int nd);
        for (int i = 0; i < nd; i++) begin
            @(negedge clk);
            start    = (i == 0);
            Data_in1 = a[63 - 4 * i -: 4];
            Data_in2 = b[63 - 4 * i -: 4];
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        Data_in1 = '0;
        Data_in2 = '0;

        // Reset, then 20 idle cycles with random data and no start.
        repeat (2) @(negedge clk);
        chk("reset_out", Data_out, 128'd0);
        rst = 1'b1;
        idle(20);
        chk("idle_out", Data_out, 128'd0);
        chk("idle_no_change", 128'(seen.size()), 128'd0);

        // 1x1 followed back-to-back by 2x3.
        seen.delete();
        send_frame(64'd1, 64'd1, 16);
        send_frame(64'd2, 64'd3, 16);
        idle(4);
        chk("b2b_count", 128'(seen.size()), 128'd2);
        chk("b2b_first", seen[0], 128'd1);
        chk("b2b_second", seen[1], 128'd6);

        // Maximum operands.
        seen.delete();
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16);
        idle(4);
        chk("max_count", 128'(seen.size()), 128'd1);
        chk("max_val", Data_out, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        // Carry across the half boundary.
        seen.delete();
        send_frame(64'h0000_0001_FFFF_FFFF, 64'h0000_0001_FFFF_FFFF, 16);
        idle(4);
        chk("cross_count", 128'(seen.size()), 128'd1);
        chk("cross_val", Data_out, 128'h3_FFFF_FFFC_0000_0001);

        seen.delete();
        send_frame(64'h1234, 64'h10, 16);
        idle(4);
        chk("small_count", 128'(seen.size()), 128'd1);
        chk("small_val", Data_out, 128'h12340);

        // Abandon a frame after 8 digits and restart with 0xFF x 0xFF.
        seen.delete();
        send_frame(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 8);
        send_frame(64'hFF, 64'hFF, 16);
        idle(4);
        chk("restart_count", 128'(seen.size()), 128'd1);
        chk("restart_val", seen[0], 128'd65025);

        // Reset on the edge after the last digit. The product must never appear.
        seen.delete();
        send_frame(64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98, 16);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(10);
        chk("midrst_count", 128'(seen.size()), 128'd1);
        chk("midrst_first", seen[0], 128'd0);
        chk("midrst_out", Data_out, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
